// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a standard (non-FWFT) synchronous FIFO, whose read data arrives one
// cycle after the read enable, and presents the words as a valid/ready stream
// with burst framing. A 2-entry holding buffer absorbs the one-cycle read
// latency. Reads are issued only when there is guaranteed space, so full
// throughput is sustained without ever overflowing the buffer.
//
// Parameters
//   WORD_SIZE        data width; must match the attached FIFO
//   BURST_LEN        words per burst (1..65536)
//
// Ports
//   i_clk            rising-edge clock
//   i_reset          asynchronous, active-high reset
//   o_fifo_re        FIFO read enable (pop request)
//   i_fifo_not_empty FIFO holds at least one word
//   i_fifo_data      FIFO read data, valid the cycle after a successful read
//   o_valid          stream word available
//   i_ready          consumer accepts the word
//   o_data           stream word (head of the holding buffer)
//   o_last           current word is the final word of a burst
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WORD_SIZE = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic                 o_fifo_re,
  input  logic                 i_fifo_not_empty,
  input  logic [WORD_SIZE-1:0] i_fifo_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_last
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Holding buffer: two slots addressed by a head pointer plus occupancy.
  logic [WORD_SIZE-1:0] mem_q [2];
  logic [WORD_SIZE-1:0] mem_d [2];
  logic                 head_q, head_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic       pop_now;
  logic       rd_fire;
  logic       tail;
  logic [2:0] credit_used;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    mem_d      = mem_q;
    head_d     = head_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;

    o_valid = (occ_q != 2'd0);
    o_data  = mem_q[head_q];
    o_last  = o_valid & (beat_cnt_q == LAST_BEAT);
    pop_now = o_valid & i_ready;

    // Slots that will be spoken for after this cycle: buffered words plus the
    // word still in the FIFO's output register, minus the one leaving now.
    // A pop implies occ_q >= 1, so this never goes negative.
    credit_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_now};
    o_fifo_re   = ~i_reset & i_fifo_not_empty & (credit_used < 3'd2);
    rd_fire     = o_fifo_re & i_fifo_not_empty;

    // The read issued last cycle is on i_fifo_data now.
    inflight_d = rd_fire;

    // Tail slot is head + occ (mod 2). A capture never coincides with occ = 2
    // because the credit rule keeps occ + inflight <= 2.
    tail = head_q ^ occ_q[0];
    if (inflight_q) begin
      mem_d[tail] = i_fifo_data;
    end

    if (pop_now) begin
      head_d     = ~head_q;
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
    end

    case ({inflight_q, pop_now})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, matching real register behaviour.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the two buffer slots are reset (not left as plain storage)
      // because o_data is read straight from them and must be 0 in reset.
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Three instances (BURST_LEN 16, 4, 1) share one FIFO model and stimulus;
// read/valid/data behaviour does not depend on BURST_LEN, so only o_last
// differs between them. The reference model works at word level: a FIFO
// queue, one pending word in the FIFO output register, and a queue of words
// available to the consumer; a read may be issued when fewer than two words
// would be outstanding after this cycle's pop.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       ne;
  logic       rdy;
  logic [7:0] fdata;

  logic       re  [3];
  logic       vld [3];
  logic       lst [3];
  logic [7:0] dat [3];

  always #5 clk = ~clk;

  fifo_stream_reader #(.WORD_SIZE(8), .BURST_LEN(16)) u_b16 (
    .i_clk(clk), .i_reset(rst), .o_fifo_re(re[0]), .i_fifo_not_empty(ne),
    .i_fifo_data(fdata), .o_valid(vld[0]), .i_ready(rdy), .o_data(dat[0]),
    .o_last(lst[0]));

  fifo_stream_reader #(.WORD_SIZE(8), .BURST_LEN(4)) u_b4 (
    .i_clk(clk), .i_reset(rst), .o_fifo_re(re[1]), .i_fifo_not_empty(ne),
    .i_fifo_data(fdata), .o_valid(vld[1]), .i_ready(rdy), .o_data(dat[1]),
    .o_last(lst[1]));

  fifo_stream_reader #(.WORD_SIZE(8), .BURST_LEN(1)) u_b1 (
    .i_clk(clk), .i_reset(rst), .o_fifo_re(re[2]), .i_fifo_not_empty(ne),
    .i_fifo_data(fdata), .o_valid(vld[2]), .i_ready(rdy), .o_data(dat[2]),
    .o_last(lst[2]));

  // ---------------- reference model state ----------------
  logic [7:0] fifo_q  [$];
  logic [7:0] avail_q [$];
  logic       pend_v;
  logic [7:0] pend_w;
  int         pops;
  int         dut_fires;
  int         dut_pops;
  logic       exp_re_c;
  logic       pop_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rdy;
    logic       re;
    logic       vld;
    logic [7:0] data;
    logic       last16;
    logic       last4;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic r, logic e, logic v, logic [7:0] d,
                              logic l16, logic l4);
    vec_t t;
    t.rdy = r; t.re = e; t.vld = v; t.data = d; t.last16 = l16; t.last4 = l4;
    return t;
  endfunction

  function automatic int burst_of(int k);
    case (k)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    avail_q.delete();
    pend_v    = 1'b0;
    pend_w    = 8'h00;
    pops      = 0;
    dut_fires = 0;
    dut_pops  = 0;
  endtask

  // Called just after a rising edge: apply this cycle's inputs.
  task automatic drive(input logic r);
    rdy   = r;
    ne    = (fifo_q.size() != 0);
    fdata = pend_w;
  endtask

  // Falling edge: compare every instance against the model.
  task automatic sample();
    logic ev;
    int   outstanding;
    @(negedge clk);
    ev       = (avail_q.size() != 0);
    pop_c    = ev && rdy;
    exp_re_c = ne && ((avail_q.size() + int'(pend_v) - int'(pop_c)) < 2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid[%0d]", k), vld[k], ev);
      check($sformatf("re[%0d]", k), re[k], exp_re_c);
      check($sformatf("last[%0d]", k), lst[k],
            ev && ((pops % burst_of(k)) == burst_of(k) - 1));
      if (ev) check($sformatf("data[%0d]", k), dat[k], avail_q[0]);
    end
    // Words requested but not yet taken, counted purely from DUT ports.
    outstanding = dut_fires - dut_pops;
    check("credit_le_2", (outstanding <= 2), 1'b1);
    if (re[0] && ne)   dut_fires++;
    if (vld[0] && rdy) dut_pops++;
  endtask

  // Rising edge: advance the model by one cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    if (pop_c) begin
      void'(avail_q.pop_front());
      pops++;
    end
    if (pend_v) avail_q.push_back(pend_w);
    pend_v = exp_re_c;
    if (exp_re_c) pend_w = fifo_q.pop_front();
  endtask

  task automatic cycle(input logic r);
    drive(r);
    sample();
    advance();
  endtask

  // Entered just after a rising edge; asserts reset asynchronously and
  // checks the outputs clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid[%0d]", k), vld[k], 1'b0);
      check($sformatf("rst_last[%0d]", k), lst[k], 1'b0);
      check($sformatf("rst_re[%0d]", k), re[k], 1'b0);
      check($sformatf("rst_data[%0d]", k), dat[k], 8'h00);
    end
    model_reset();
    drive(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_left;
    int rd_at;
    int v_at;
    int idx;
    int pushed;
    logic [7:0] seed_w;

    // Streaming table: 8 preloaded words 0x10..0x17, ready held high.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    rst   = 1'b0;
    rdy   = 1'b0;
    ne    = 1'b0;
    fdata = 8'h00;
    model_reset();
    #2;
    apply_reset();

    // ---- streaming ----
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rdy);
      sample();
      check($sformatf("tbl_re[%0d]", i), re[0], tbl[i].re);
      check($sformatf("tbl_valid[%0d]", i), vld[0], tbl[i].vld);
      if (tbl[i].vld) check($sformatf("tbl_data[%0d]", i), dat[0], tbl[i].data);
      check($sformatf("tbl_last16[%0d]", i), lst[0], tbl[i].last16);
      check($sformatf("tbl_last4[%0d]", i), lst[1], tbl[i].last4);
      check($sformatf("tbl_last1[%0d]", i), lst[2], tbl[i].vld);
      advance();
    end

    // ---- backpressure: stall 6 cycles after the 3rd pop ----
    apply_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h20 + 8'(i));
    stall_left = 6;
    for (int c = 0; c < 40; c++) begin
      if (pops >= 3 && stall_left > 0) begin
        drive(1'b0);
        sample();
        check("bp_hold_valid", vld[0], 1'b1);
        check("bp_hold_data", dat[0], 8'h23);
        stall_left--;
        advance();
      end else begin
        cycle(1'b1);
      end
    end
    check("bp_count", dut_pops, 16);

    // ---- framing: 10 words, pause, then 2 more ----
    apply_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(i));
    for (int c = 0; c < 60; c++) begin
      if (c == 40) begin
        fifo_q.push_back(8'd10);
        fifo_q.push_back(8'd11);
      end
      drive($urandom_range(0, 3) != 0);
      sample();
      if (vld[1] && rdy)
        check("frame_last4", lst[1], (dat[1] == 8'd3 || dat[1] == 8'd7 || dat[1] == 8'd11));
      if (vld[2]) check("frame_last1", lst[2], 1'b1);
      advance();
      if (c == 35) check("frame_first10", dut_pops, 10);
    end
    check("frame_total", dut_pops, 12);

    // ---- underflow: FIFO runs empty between words ----
    apply_reset();
    fifo_q.push_back(8'h31);
    for (int c = 0; c < 3; c++) cycle(1'b1);
    fifo_q.push_back(8'h32);
    for (int c = 0; c < 2; c++) cycle(1'b1);
    fifo_q.push_back(8'h33);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1);
      sample();
      if (!ne) check("uf_no_re", re[0], 1'b0);
      advance();
    end
    check("uf_three", dut_pops, 3);
    for (int c = 0; c < 4; c++) cycle(1'b1);
    fifo_q.push_back(8'h34);
    rd_at = -1;
    v_at  = -1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1);
      sample();
      if (re[0] && ne && rd_at < 0) rd_at = c;
      if (vld[0] && v_at < 0) v_at = c;
      advance();
    end
    check("uf_latency", v_at - rd_at, 2);
    check("uf_four", dut_pops, 4);

    // ---- randomized traffic ----
    apply_reset();
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          seed_w = 8'($urandom);
          fifo_q.push_back(seed_w);
          pushed++;
        end
      end
      cycle($urandom_range(0, 9) < 7);
    end
    for (int c = 0; c < 200 && (fifo_q.size() != 0 || avail_q.size() != 0 || pend_v); c++)
      cycle(1'b1);
    cycle(1'b1);
    check("rand_total", dut_pops, pushed);

    // ---- asynchronous reset mid-stream ----
    apply_reset();
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h50 + 8'(i));
    for (int c = 0; c < 20 && !(pops >= 2 && (avail_q.size() + int'(pend_v)) == 2); c++)
      cycle(1'b1);
    drive(1'b1);
    apply_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1'b1);
      sample();
      if (vld[1] && rdy) begin
        if (idx == 0) check("rst_first_word", dat[1], 8'hA0);
        check("rst_beat_restart", lst[1], (idx % 4) == 3);
        idx++;
      end
      advance();
    end
    check("rst_reload_count", dut_pops, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
